ddio_out_reg: RTL and testbench



---
 rtl/ddio_out_reg.sv | 89 ++++++++
 tb/tb_ddio_out_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ddio_out_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ddio_out_reg : vendor-neutral DDR output register (high phase / low phase mux)
// Optional feature: define DDIO_OE_REG_EN to register oe on the rising edge.
// Rev 1.0
//------------------------------------------------------------------------------
module ddio_out_reg #(
  parameter int WIDTH         = 1,
  parameter bit INVERT_OUTPUT = 1'b0,
  parameter bit POWER_UP_HIGH = 1'b0
) (
  input  logic             sd_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] datain_h,
  input  logic [WIDTH-1:0] datain_l,
  input  logic             outclocken,
  input  logic             oe,
  input  logic             sclr,
  input  logic             sset,
  input  logic             aclr,
  input  logic             aset,
  output logic [WIDTH-1:0] dataout
);

  localparam logic [WIDTH-1:0] c_init_val = {WIDTH{POWER_UP_HIGH}};
  localparam logic [WIDTH-1:0] c_inv_mask = {WIDTH{INVERT_OUTPUT}};

  logic [WIDTH-1:0] r_h  = c_init_val;
  logic [WIDTH-1:0] r_l  = c_init_val;
  logic [WIDTH-1:0] r_ln = c_init_val;
  logic [WIDTH-1:0] w_phase_data;
  logic             w_oe_eff;

  always_ff @(posedge sd_clk or posedge aclr or posedge aset) begin
    if (aclr) begin
      r_h <= '0;
      r_l <= '0;
    end else if (aset) begin
      r_h <= '1;
      r_l <= '1;
    end else if (reset) begin
      r_h <= c_init_val;
      r_l <= c_init_val;
    end else if (sclr) begin
      r_h <= '0;
      r_l <= '0;
    end else if (sset) begin
      r_h <= '1;
      r_l <= '1;
    end else if (outclocken) begin
      r_h <= datain_h;
      r_l <= datain_l;
    end
  end

  // Retiming the low-phase value to the falling edge keeps it stable for the whole low phase.
  always_ff @(negedge sd_clk or posedge aclr or posedge aset) begin
    if (aclr) begin
      r_ln <= '0;
    end else if (aset) begin
      r_ln <= '1;
    end else begin
      r_ln <= r_l;
    end
  end

`ifdef DDIO_OE_REG_EN
  logic r_oe = 1'b0;

  always_ff @(posedge sd_clk or posedge aclr) begin
    if (aclr) begin
      r_oe <= 1'b0;
    end else if (reset) begin
      r_oe <= 1'b0;
    end else begin
      r_oe <= oe;
    end
  end

  assign w_oe_eff = r_oe;
`else
  assign w_oe_eff = oe;
`endif

  assign w_phase_data = sd_clk ? r_h : r_ln;
  assign dataout      = w_oe_eff ? (w_phase_data ^ c_inv_mask) : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ddio_out_reg.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_ddio_out_reg : directed self-checking bench with a captured-pair model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_ddio_out_reg;

  localparam int W = 4;
`ifdef DDIO_OE_REG_EN
  localparam bit OE_REG = 1'b1;
`else
  localparam bit OE_REG = 1'b0;
`endif

  logic sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  logic         reset = 1'b1, outclocken = 1'b1, oe = 1'b1;
  logic         sclr = 1'b0, sset = 1'b0, aclr = 1'b0, aset = 1'b0;
  logic [W-1:0] datain_h = 4'hF, datain_l = 4'hF;
  wire  [W-1:0] dataout;

  logic         lo = 1'b0, hi = 1'b1;
  wire  [0:0]   dout_fwd;

  ddio_out_reg #(.WIDTH(W), .INVERT_OUTPUT(1'b0), .POWER_UP_HIGH(1'b0)) dut (
    .sd_clk(sd_clk), .reset(reset), .datain_h(datain_h), .datain_l(datain_l),
    .outclocken(outclocken), .oe(oe), .sclr(sclr), .sset(sset),
    .aclr(aclr), .aset(aset), .dataout(dataout)
  );

  // Inverted clock-forward instance: h=0, l=1 must reproduce sd_clk itself.
  ddio_out_reg #(.WIDTH(1), .INVERT_OUTPUT(1'b1), .POWER_UP_HIGH(1'b1)) dut_fwd (
    .sd_clk(sd_clk), .reset(lo), .datain_h(lo), .datain_l(hi),
    .outclocken(hi), .oe(hi), .sclr(lo), .sset(lo),
    .aclr(lo), .aset(lo), .dataout(dout_fwd)
  );

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp, bit want_z);
    nchk++;
    if (want_z) begin
      if (!((act === '0) || (act === {W{1'bz}}))) begin
        nerr++;
        $display("FAIL %s: got %h, want high-Z at t=%0t", name, act, $time);
      end
    end else if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the pair captured at the last rising edge, plus the low value
  // made visible at the following falling edge.
  logic [W-1:0] m_h = '0, m_l = '0, m_show_l = '0;
  bit           m_oe = 1'b0;

  function automatic logic [W-1:0] next_val(logic [W-1:0] cur, logic [W-1:0] din);
    if (reset || sclr) return '0;
    if (sset)          return '1;
    return outclocken ? din : cur;
  endfunction

  always @(posedge sd_clk) begin
    ncyc++;
    if (aclr) begin
      m_h = '0; m_l = '0;
    end else if (aset) begin
      m_h = '1; m_l = '1;
    end else begin
      m_h = next_val(m_h, datain_h);
      m_l = next_val(m_l, datain_l);
    end
    m_oe = !aclr && !reset && oe;
  end

  always @(negedge sd_clk) begin
    m_show_l = aclr ? '0 : (aset ? '1 : m_l);
  end

  always @(posedge aclr or posedge aset) begin
    if (aclr) begin
      m_h = '0; m_l = '0; m_show_l = '0; m_oe = 1'b0;
    end else begin
      m_h = '1; m_l = '1; m_show_l = '1;
    end
  end

  initial begin
    @(posedge sd_clk);
    forever begin
      @(sd_clk);
      #2;
      check("model", dataout, sd_clk ? m_h : m_show_l, !(OE_REG ? m_oe : oe));
      if (ncyc >= 3)
        check("clk_fwd", {3'b000, dout_fwd}, {3'b000, sd_clk}, 1'b0);
    end
  end

  task automatic setd(logic [W-1:0] h, logic [W-1:0] l);
    datain_h = h;
    datain_l = l;
  endtask

  task automatic chk_hi(string n, logic [W-1:0] e, bit z = 1'b0);
    @(posedge sd_clk); #2;
    check(n, dataout, e, z);
  endtask

  task automatic chk_lo(string n, logic [W-1:0] e, bit z = 1'b0);
    @(negedge sd_clk); #2;
    check(n, dataout, e, z);
  endtask

  initial begin
    repeat (2) @(posedge sd_clk);
    chk_hi("reset_hi", 4'h0);
    chk_lo("reset_lo", 4'h0);
    reset = 1'b0;

    setd(4'h0, 4'hF);
    chk_hi("fwd_hi", 4'h0);  chk_lo("fwd_lo", 4'hF);
    chk_hi("fwd_hi2", 4'h0); chk_lo("fwd_lo2", 4'hF);

    setd(4'hA, 4'h5);
    chk_hi("data_A", 4'hA); chk_lo("data_5", 4'h5);
    setd(4'h3, 4'hC);
    chk_hi("data_3", 4'h3); chk_lo("data_C", 4'hC);

    setd(4'h1, 4'h2);
    chk_hi("pre_rst_hi", 4'h1); chk_lo("pre_rst_lo", 4'h2);
    reset = 1'b1;
    setd(4'h7, 4'h8);
    chk_hi("mid_rst_hi", 4'h0); chk_lo("mid_rst_lo", 4'h0);
    reset = 1'b0;
    setd(4'h9, 4'h6);
    chk_hi("resume_hi", 4'h9); chk_lo("resume_lo", 4'h6);

    setd(4'h4, 4'hB);
    chk_hi("pair_hi", 4'h4); chk_lo("pair_lo", 4'hB);
    outclocken = 1'b0;
    setd(4'h1, 4'h1);
    chk_hi("hold_hi", 4'h4); chk_lo("hold_lo", 4'hB);
    setd(4'h2, 4'h2);
    chk_hi("hold_hi2", 4'h4); chk_lo("hold_lo2", 4'hB);

    sclr = 1'b1;
    chk_hi("sclr_hi", 4'h0); chk_lo("sclr_lo", 4'h0);
    sclr = 1'b0; sset = 1'b1;
    chk_hi("sset_hi", 4'hF); chk_lo("sset_lo", 4'hF);
    sset = 1'b0; reset = 1'b1;
    setd(4'h5, 4'h5);
    chk_hi("rst_over_ce_hi", 4'h0); chk_lo("rst_over_ce_lo", 4'h0);
    reset = 1'b0; outclocken = 1'b1;
    setd(4'hE, 4'h7);
    chk_hi("run_hi", 4'hE); chk_lo("run_lo", 4'h7);

    chk_hi("oe_pre", 4'hE);
    #1 oe = 1'b0;
    #1 check("oe_off_now", dataout, 4'hE, !OE_REG);
    chk_lo("oe_off_lo", 4'h7, !OE_REG);
    chk_hi("oe_off_hi", 4'h0, 1'b1);
    #1 oe = 1'b1;
    #1 check("oe_on_now", dataout, 4'hE, OE_REG);
    chk_lo("oe_on_lo", 4'h7, OE_REG);
    chk_hi("oe_on_hi", 4'hE);

    #1 aclr = 1'b1;
    #1 check("aclr_now", dataout, 4'h0, OE_REG);
    aclr = 1'b0;
    chk_lo("aclr_lo", 4'h0, OE_REG);
    chk_hi("after_aclr", 4'hE);
    #1 aset = 1'b1;
    #1 check("aset_now", dataout, 4'hF, 1'b0);
    aset = 1'b0;
    chk_lo("aset_lo", 4'hF);
    chk_hi("after_aset", 4'hE);
    #1 begin aclr = 1'b1; aset = 1'b1; end
    #1 check("aclr_aset_now", dataout, 4'h0, OE_REG);
    aclr = 1'b0; aset = 1'b0;
    chk_lo("aclr_aset_lo", 4'h0, OE_REG);
    chk_hi("final_hi", 4'hE);
    chk_lo("final_lo", 4'h7);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
